pipe_reg_skid: RTL and testbench
================================

# pipe_reg_skid

Parametrised pipeline-stage register for the pipelined CPU datapath, replacing fixed 32-bit enable/clear register banks between stages. It adds a valid/ready handshake with a one-entry skid buffer, so a stall can propagate backwards one stage per cycle without dropping data. It also provides a synchronous flush that inserts a bubble, and a selectable capture edge. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- WIDTH, 32: data width in bits (≥1).
- RESET_VAL, {WIDTH{1'b0}}: value loaded into both data registers on reset and flush.
- NEG_EDGE, 1: 1 = all state updates on falling edge of Clk; 0 = rising edge.

Ports:
- Clk  in  1  stage clock.
- Clrn  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous bubble insert; sampled on the active edge.
- D  in  WIDTH  upstream data.
- In_Valid  in  1  upstream presents D.
- In_Ready  out  1  stage accepts D on this active edge.
- Q  out  WIDTH  downstream data (main register).
- Qn  out  WIDTH  bitwise ~Q.
- Out_Valid  out  1  Q holds a valid item.
- Out_Ready  in  1  downstream consumes Q on this active edge.
- Count  out  2  occupancy (0, 1 or 2).

## Operation
- Storage: main register M (drives Q) and skid register S. State is EMPTY (0 items), ONE (M valid) or TWO (M and S valid).
- Outputs are decoded from state only; no combinational path from any input to any output:
  - Out_Valid = (state != EMPTY).
  - In_Ready = (state != TWO).
  - Count = 0/1/2 for EMPTY/ONE/TWO.
- Accept = In_Valid & In_Ready. Consume = Out_Valid & Out_Ready.
- Transitions on each active edge when Flush=0:
  - EMPTY: Accept → M<=D, ONE. Otherwise stay.
  - ONE:
    - Accept & Consume → M<=D, ONE.
    - Consume only → EMPTY (M keeps its value).
    - Accept only → S<=D, TWO.
    - Neither → ONE.
  - TWO: Consume → M<=S, ONE. Otherwise stay (In_Ready=0, D ignored).
- Ordering is strict FIFO: an item in S always leaves after the item in M.
- Flush=1 on an active edge:
  - State goes to EMPTY, M<=RESET_VAL, S<=RESET_VAL.
  - Any concurrent Accept or Consume is discarded; upstream must treat the presented item as dropped.
  - Flush has priority over all handshake activity.
- Reset (Clrn=0), asynchronous and independent of Clk:
  - State EMPTY, M=S=RESET_VAL.
  - Q=RESET_VAL, Qn=~RESET_VAL, Out_Valid=0, In_Ready=1, Count=0.
  - Holds while Clrn=0. Reset mid-transfer drops all content.
- Release: first state update is on the first active edge after Clrn rises.
- Qn is always exactly ~Q, including during reset.

## Timing
- Latency: D accepted on edge k appears on Q, with Out_Valid=1, immediately after edge k. Latency is 1 active edge.
- Throughput: one item per active edge when Out_Ready stays high. Steady state is ONE and S is never used.
- Stall propagation: In_Ready falls one edge after Out_Ready falls, and only if an item arrived in that edge.
- Recovery: In_Ready rises on the edge where the TWO-state item is consumed.
- Edges: NEG_EDGE=1 updates on negedge Clk only; NEG_EDGE=0 on posedge only. The inactive edge never changes state.
- Producer rule: upstream must hold D stable while In_Valid=1 & In_Ready=0. The block does not check this.

## Test plan
- Reset: assert Clrn=0 mid-run with state TWO and WIDTH=32, RESET_VAL=32'h0000_0000. Expect Q=0, Qn=32'hFFFF_FFFF, Out_Valid=0, In_Ready=1 and Count=0 immediately, without a clock edge.
- Streaming: Out_Ready=1, In_Valid=1, D=1,2,3,4 on consecutive edges. Expect Q=1,2,3,4 one edge behind, Count=1 throughout, In_Ready never 0.
- Stall/skid:
  - Drive D=A, then drop Out_Ready and drive D=B. Expect Q=A, Count=2, In_Ready=0, and D=C ignored.
  - Raise Out_Ready. Expect Q=B next edge, then C accepted after In_Ready returns to 1.
- Flush priority: in state TWO with In_Valid=1, Out_Ready=1 and Flush=1, with RESET_VAL=32'hDEAD_BEEF. Expect next edge Q=32'hDEAD_BEEF, Out_Valid=0, Count=0, and no item emitted later.
- Edge mode: instantiate NEG_EDGE=0 and NEG_EDGE=1 side by side with WIDTH=8 and D=8'h5A. Expect Q to change only on posedge and only on negedge respectively.
- Random: run 10k cycles with random In_Valid, Out_Ready and Flush at 5%. Check against a scoreboard: no loss, no duplication, order preserved except items dropped by flush, Count ≤ 2.

Source files
------------

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: pipeline-stage register with a valid/ready handshake and a
// one-entry skid buffer. A downstream stall costs at most one extra entry,
// so In_Ready can be a pure register decode with no input-to-output path.
// Flush empties the stage and reloads both data registers with RESET_VAL.
// NEG_EDGE selects which clock edge updates the state.
module pipe_reg_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter bit               NEG_EDGE  = 1'b1
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             Flush,
  input  logic [WIDTH-1:0] D,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [1:0]       Count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] m_nxt_s;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] s_nxt_s;
  logic             accept_s;
  logic             consume_s;

  // Handshake flags and outputs decode only from the registered state
  assign Out_Valid = (state_r != ST_EMPTY);
  assign In_Ready  = (state_r != ST_TWO);
  assign Count     = (state_r == ST_TWO) ? 2'd2 :
                     (state_r == ST_ONE) ? 2'd1 : 2'd0;
  assign Q         = m_r;
  assign Qn        = ~m_r;
  assign accept_s  = In_Valid & In_Ready;
  assign consume_s = Out_Valid & Out_Ready;

  // Next-state and next-data selection; flush overrides every handshake
  always_comb begin
    state_nxt_s = state_r;
    m_nxt_s     = m_r;
    s_nxt_s     = s_r;
    if (Flush) begin
      state_nxt_s = ST_EMPTY;
      m_nxt_s     = RESET_VAL;
      s_nxt_s     = RESET_VAL;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            m_nxt_s     = D;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && consume_s) begin
            m_nxt_s     = D;
            state_nxt_s = ST_ONE;
          end else if (consume_s) begin
            // main register keeps its stale value while empty
            state_nxt_s = ST_EMPTY;
          end else if (accept_s) begin
            s_nxt_s     = D;
            state_nxt_s = ST_TWO;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (consume_s) begin
            // skid item moves up; it is older than anything upstream
            m_nxt_s     = s_r;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          m_nxt_s     = RESET_VAL;
          s_nxt_s     = RESET_VAL;
        end
      endcase
    end
  end

  generate
    if (NEG_EDGE) begin : g_neg
      // State and data registers, updated on the falling clock edge
      always_ff @(negedge Clk or negedge Clrn) begin
        if (!Clrn) begin
          state_r <= ST_EMPTY;
          m_r     <= RESET_VAL;
          s_r     <= RESET_VAL;
        end else begin
          state_r <= state_nxt_s;
          m_r     <= m_nxt_s;
          s_r     <= s_nxt_s;
        end
      end
    end else begin : g_pos
      // State and data registers, updated on the rising clock edge
      always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
          state_r <= ST_EMPTY;
          m_r     <= RESET_VAL;
          s_r     <= RESET_VAL;
        end else begin
          state_r <= state_nxt_s;
          m_r     <= m_nxt_s;
          s_r     <= s_nxt_s;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed checks of reset, streaming, skid stall, flush
// priority and edge selection, followed by a random run against a queue model.
module tb_pipe_reg_skid;

  logic        Clk;
  logic        clrn;
  logic        flush;
  logic [31:0] d;
  logic        in_valid;
  logic        out_ready;

  logic        ir_a, ov_a, ir_f, ov_f;
  logic [31:0] q_a, qn_a, q_f, qn_f;
  logic [1:0]  cnt_a, cnt_f;

  logic        flush8;
  logic [7:0]  d8;
  logic        iv8, or8;
  logic        ir8p, ov8p, ir8n, ov8n;
  logic [7:0]  q8p, qn8p, q8n, qn8n;
  logic [1:0]  c8p, c8n;

  int total;
  int passed;

  logic [31:0] mq[$];
  logic [31:0] mq_q;
  bit          cons;
  bit          acc;

  pipe_reg_skid #(.WIDTH(32), .RESET_VAL(32'h0000_0000), .NEG_EDGE(1'b1)) dut (
    .Clk(Clk), .Clrn(clrn), .Flush(flush), .D(d), .In_Valid(in_valid),
    .In_Ready(ir_a), .Q(q_a), .Qn(qn_a), .Out_Valid(ov_a),
    .Out_Ready(out_ready), .Count(cnt_a));

  pipe_reg_skid #(.WIDTH(32), .RESET_VAL(32'hDEAD_BEEF), .NEG_EDGE(1'b1)) dut_f (
    .Clk(Clk), .Clrn(clrn), .Flush(flush), .D(d), .In_Valid(in_valid),
    .In_Ready(ir_f), .Q(q_f), .Qn(qn_f), .Out_Valid(ov_f),
    .Out_Ready(out_ready), .Count(cnt_f));

  pipe_reg_skid #(.WIDTH(8), .RESET_VAL(8'h00), .NEG_EDGE(1'b0)) dut8p (
    .Clk(Clk), .Clrn(clrn), .Flush(flush8), .D(d8), .In_Valid(iv8),
    .In_Ready(ir8p), .Q(q8p), .Qn(qn8p), .Out_Valid(ov8p),
    .Out_Ready(or8), .Count(c8p));

  pipe_reg_skid #(.WIDTH(8), .RESET_VAL(8'h00), .NEG_EDGE(1'b1)) dut8n (
    .Clk(Clk), .Clrn(clrn), .Flush(flush8), .D(d8), .In_Valid(iv8),
    .In_Ready(ir8n), .Q(q8n), .Qn(qn8n), .Out_Valid(ov8n),
    .Out_Ready(or8), .Count(c8n));

  // Free-running clock, period 10
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wait for the main DUT's active (falling) edge, then settle
  task automatic edge_step();
    @(negedge Clk);
    #1;
  endtask

  initial begin
    total = 0; passed = 0;
    clrn = 1'b0; flush = 1'b0; d = 32'd0; in_valid = 1'b0; out_ready = 1'b0;
    flush8 = 1'b0; d8 = 8'h00; iv8 = 1'b0; or8 = 1'b0;

    // Reset state
    #12;
    chk("rst_q",   q_a, 32'h0000_0000);
    chk("rst_qn",  qn_a, 32'hFFFF_FFFF);
    chk("rst_ov",  {31'd0, ov_a}, 32'd0);
    chk("rst_ir",  {31'd0, ir_a}, 32'd1);
    chk("rst_cnt", {30'd0, cnt_a}, 32'd0);
    clrn = 1'b1;

    // Streaming 1..4 with downstream always ready
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      d = 32'(k);
      edge_step();
      chk("stream_q",   q_a, 32'(k));
      chk("stream_cnt", {30'd0, cnt_a}, 32'd1);
      chk("stream_ir",  {31'd0, ir_a}, 32'd1);
    end

    // Stall and skid: A, then B with downstream stalled, C ignored
    d = 32'h0000_000A; edge_step();
    chk("skid_qa", q_a, 32'h0000_000A);
    out_ready = 1'b0; d = 32'h0000_000B; edge_step();
    chk("skid_q_two",   q_a, 32'h0000_000A);
    chk("skid_cnt_two", {30'd0, cnt_a}, 32'd2);
    chk("skid_ir_two",  {31'd0, ir_a}, 32'd0);
    d = 32'h0000_000C; edge_step();
    chk("skid_c_ign_q",   q_a, 32'h0000_000A);
    chk("skid_c_ign_cnt", {30'd0, cnt_a}, 32'd2);
    out_ready = 1'b1; edge_step();
    chk("skid_qb",   q_a, 32'h0000_000B);
    chk("skid_cnt1", {30'd0, cnt_a}, 32'd1);
    chk("skid_ir1",  {31'd0, ir_a}, 32'd1);
    edge_step();
    chk("skid_qc", q_a, 32'h0000_000C);
    in_valid = 1'b0; edge_step();
    chk("drain_ov",  {31'd0, ov_a}, 32'd0);
    chk("drain_cnt", {30'd0, cnt_a}, 32'd0);
    chk("drain_q",   q_a, 32'h0000_000C);

    // Asynchronous reset while holding two items
    in_valid = 1'b1; out_ready = 1'b0; d = 32'h11; edge_step();
    d = 32'h22; edge_step();
    chk("arst_pre_cnt", {30'd0, cnt_a}, 32'd2);
    #2 clrn = 1'b0;
    #1;
    chk("arst_q",   q_a, 32'h0000_0000);
    chk("arst_qn",  qn_a, 32'hFFFF_FFFF);
    chk("arst_ov",  {31'd0, ov_a}, 32'd0);
    chk("arst_ir",  {31'd0, ir_a}, 32'd1);
    chk("arst_cnt", {30'd0, cnt_a}, 32'd0);
    edge_step();
    chk("arst_hold_cnt", {30'd0, cnt_a}, 32'd0);
    clrn = 1'b1;

    // Flush priority while full, with valid and ready also asserted
    in_valid = 1'b1; out_ready = 1'b0; d = 32'h33; edge_step();
    d = 32'h44; edge_step();
    chk("fl_pre_cnt", {30'd0, cnt_f}, 32'd2);
    chk("fl_pre_q",   q_f, 32'h0000_0033);
    d = 32'h55; out_ready = 1'b1; flush = 1'b1; edge_step();
    chk("fl_q",    q_f, 32'hDEAD_BEEF);
    chk("fl_qn",   qn_f, 32'h2152_4110);
    chk("fl_ov",   {31'd0, ov_f}, 32'd0);
    chk("fl_cnt",  {30'd0, cnt_f}, 32'd0);
    chk("fl_ir",   {31'd0, ir_f}, 32'd1);
    chk("fl_q0",   q_a, 32'h0000_0000);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      edge_step();
      chk("fl_after_ov", {31'd0, ov_f}, 32'd0);
      chk("fl_after_q",  q_f, 32'hDEAD_BEEF);
    end

    // Edge selection: posedge and negedge instances side by side
    d8 = 8'h5A; iv8 = 1'b1; or8 = 1'b1;
    @(posedge Clk); #1;
    chk("edge_p_q1",  {24'd0, q8p}, 32'h5A);
    chk("edge_n_q1",  {24'd0, q8n}, 32'h00);
    chk("edge_n_ov1", {31'd0, ov8n}, 32'd0);
    @(negedge Clk); #1;
    chk("edge_n_q2",  {24'd0, q8n}, 32'h5A);
    chk("edge_n_qn2", {24'd0, qn8n}, 32'hA5);
    d8 = 8'hA5;
    @(posedge Clk); #1;
    chk("edge_p_q3",  {24'd0, q8p}, 32'hA5);
    chk("edge_p_qn3", {24'd0, qn8p}, 32'h5A);
    chk("edge_n_q3",  {24'd0, q8n}, 32'h5A);
    iv8 = 1'b0;
    @(negedge Clk); #1;
    chk("edge_p_q4",  {24'd0, q8p}, 32'hA5);
    chk("edge_p_ov4", {31'd0, ov8p}, 32'd1);
    chk("edge_n_ov4", {31'd0, ov8n}, 32'd0);
    chk("edge_n_q4",  {24'd0, q8n}, 32'h5A);
    chk("edge_ir",    {30'd0, ir8p, ir8n}, 32'd3);
    chk("edge_cnt",   {28'd0, c8p, c8n}, 32'h4);

    // Random traffic against a queue model; DUT is empty with Q=0 here
    mq.delete();
    mq_q = 32'h0;
    for (int i = 0; i < 10000; i++) begin
      flush     = ($urandom_range(99) < 5);
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      d         = $urandom;
      cons = (mq.size() > 0) && out_ready;
      acc  = in_valid && (mq.size() < 2);
      edge_step();
      if (flush) begin
        mq.delete();
        mq_q = 32'h0;
      end else begin
        if (cons) void'(mq.pop_front());
        if (acc)  mq.push_back(d);
        if (mq.size() > 0) mq_q = mq[0];
      end
      chk("rnd_q",   q_a, mq_q);
      chk("rnd_cnt", {30'd0, cnt_a}, 32'(mq.size()));
      chk("rnd_ov",  {31'd0, ov_a}, 32'(mq.size() > 0));
      chk("rnd_ir",  {31'd0, ir_a}, 32'(mq.size() < 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
